riscv_muldiv: RTL
=================

Name: riscv_muldiv

Overview:
- Iterative RV32M/RV64M multiply/divide unit, parametrised in data width.
- Sits beside the ALU in the execute stage of the core datapath.
- Accepts one operation per start pulse, computes it over multiple cycles, and returns the result with a one-cycle done pulse.
- The datapath stalls the pipeline while the unit is busy.

Parameters:
- DATA_W, 32: operand and result width; any even value >= 8.
- CNT_W, $clog2(DATA_W)+1: iteration counter width; derived, not overridden.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- flush  in  1  synchronous kill of the in-flight operation (branch/exception flush).
- funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  DATA_W  rs1 value; multiplicand or dividend.
- op_b  in  DATA_W  rs2 value; multiplier or divisor.
- busy  out  1  high in CALC and FIX states.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  DATA_W  final result; held until the next done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset asserted mid-operation aborts it and produces no done.
- FSM states and transitions:
  - IDLE: on start, latch funct3, op_a, op_b. Go to CALC, or directly to DONE when a special case applies.
  - CALC: performs exactly DATA_W iterations, then goes to FIX.
  - FIX: one cycle, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Sign handling (at latch):
  - Signed operand: MULH, DIV, REM use both operands; MULHSU uses op_a only.
  - Signed operands are replaced by their magnitude.
  - neg_res = sign(a) XOR sign(b) for mul/quotient; sign(a) for remainder.
- Multiply: unsigned shift-add over a 2*DATA_W accumulator, one multiplier bit per CALC cycle. FIX negates the accumulator (two's complement, 2*DATA_W) if neg_res. MUL returns the low DATA_W bits; MULH/MULHSU/MULHU return the high DATA_W bits.
- Divide: restoring division, one quotient bit per CALC cycle. FIX negates the quotient and/or remainder per neg_res.
- Special cases (IDLE to DONE, done 1 cycle after start):
  - Divisor 0: quotient = all ones; remainder = op_a unmodified.
  - Signed overflow (op_a = 1 followed by zeros, op_b = all ones): DIV result = op_a; REM result = 0.
- Latency:
  - Normal case: start sampled in cycle 0, done in cycle DATA_W+2 (34 for DATA_W=32).
  - busy is high from cycle 1 through cycle DATA_W+1.
- start while not in IDLE: ignored; no queueing.
- flush:
  - In CALC or FIX: return to IDLE next cycle, no done, result unchanged.
  - In DONE: done still pulses (the instruction has already completed).
  - flush and start in the same IDLE cycle: flush wins, nothing launched.
- Back-to-back: a start in the cycle after DONE (state back in IDLE) is accepted. Minimum issue interval is DATA_W+3 cycles for normal ops and 2 cycles for special cases.
- Operand inputs may change after the start cycle without effect.
- All arithmetic is on unsigned magnitudes. No X propagation from unlatched inputs.

Decomposition:
- riscv_muldiv_pkg holds:
  - md_op_e enum for the 8 funct3 encodings;
  - md_state_e enum {IDLE, CALC, FIX, DONE};
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- No sub-module; one FSM with shared accumulator and counter registers, about 250 lines.

Test Plan (DATA_W=32):
- MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 cycles after start; busy high for cycles 1..33.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Each gives done 1 cycle after start, busy never high.
- Launch DIV 100/7, assert flush in cycle 10 -> no done, busy low from cycle 11, result keeps its previous value. Repeat with reset pulsed low in cycle 10 -> all outputs 0 immediately.
- Pulse start during CALC with different operands -> ignored, first result correct. Issue MUL 3*4 in the cycle after done -> 12 after 34 more cycles.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   function automatic logic is_div(input md_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_rem(input md_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_a(input md_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input md_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per cycle, with sign fix-up in a final cycle.
module riscv_muldiv
   import riscv_muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   md_state_e           state, state_nxt;
   md_op_e              op_q, op_in;
   logic                neg_q;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   dvsr;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   res_q;

   // Launch-time decode on the raw inputs
   logic              launch, sa, sb, div0, ovf, special, neg_in;
   logic [DATA_W-1:0] a_mag, b_mag, spec_res;

   assign op_in   = md_op_e'(funct3);
   assign launch  = (state == IDLE) && start && !flush;
   assign sa      = is_signed_a(op_in) & op_a[DATA_W-1];
   assign sb      = is_signed_b(op_in) & op_b[DATA_W-1];
   assign a_mag   = sa ? -op_a : op_a;
   assign b_mag   = sb ? -op_b : op_b;
   assign neg_in  = is_rem(op_in) ? sa : (sa ^ sb);
   assign div0    = is_div(op_in) && (op_b == '0);
   assign ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (op_a == MIN_NEG) && (op_b == '1);
   assign special = div0 | ovf;

   always_comb begin
      spec_res = '0;
      if (div0)
         spec_res = is_rem(op_in) ? op_a : '1;
      else
         spec_res = is_rem(op_in) ? '0 : op_a;
   end

   // One iteration. acc = {hi, lo}: multiply keeps {partial product, multiplier},
   // divide keeps {partial remainder, dividend/quotient bits}.
   logic [DATA_W:0]     mul_sum, rem_sh, diff;
   logic [2*DATA_W-1:0] step;

   assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, dvsr} : '0);
   assign rem_sh  = acc[2*DATA_W-1:DATA_W-1];
   assign diff    = rem_sh - {1'b0, dvsr};
   assign step    = is_div(op_q)
                  ? {(diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0]),
                     acc[DATA_W-2:0], ~diff[DATA_W]}
                  : {mul_sum, acc[DATA_W-1:1]};

   // Sign fix-up and result selection
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   quo, rem, fix_res;

   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
   assign rem  = neg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

   always_comb begin
      fix_res = '0;
      case (op_q)
         OP_MUL:                        fix_res = prod[DATA_W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*DATA_W-1:DATA_W];
         OP_DIV, OP_DIVU:               fix_res = quo;
         OP_REM, OP_REMU:               fix_res = rem;
         default:                       fix_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (launch) state_nxt = special ? DONE : CALC;
         CALC: begin
            if (flush)             state_nxt = IDLE;
            else if (cnt == LAST)  state_nxt = FIX;
         end
         FIX:  state_nxt = flush ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q  <= OP_MUL;
         neg_q <= 1'b0;
         acc   <= '0;
         dvsr  <= '0;
         cnt   <= '0;
         res_q <= '0;
      end else begin
         case (state)
            IDLE: if (launch) begin
               op_q  <= op_in;
               neg_q <= neg_in;
               acc   <= {{DATA_W{1'b0}}, a_mag};
               dvsr  <= b_mag;
               cnt   <= '0;
               if (special) res_q <= spec_res;
            end
            CALC: if (!flush) begin
               acc <= step;
               cnt <= cnt + 1'b1;
            end
            // Result only commits when the op survives FIX, so a flush keeps the old value
            FIX: if (!flush) res_q <= fix_res;
            default: ;
         endcase
      end
   end

   assign busy   = (state == CALC) || (state == FIX);
   assign done   = (state == DONE);
   assign result = res_q;

endmodule
